// File: rtl/data_memory_controller_pkg.sv
// dmc_pkg: shared FSM states, access-size encoding and lane widths for the data memory controller.
package dmc_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, MERGE} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int WORD_W = 32;
  function automatic size_e dec_size(logic is_byte, logic is_half);
    return is_byte ? SZ_BYTE : is_half ? SZ_HALF : SZ_WORD;
  endfunction
endpackage

// File: rtl/data_memory_controller_if.sv
// data_memory_controller_if: MEM-stage request bus plus RAM port; misaligned exists only with DMC_ALIGN_CHECK_EN.
interface data_memory_controller_if #(parameter int ADDR_WIDTH = 10);
  logic                  req_read;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  req_byte;
  logic                  req_half;
  logic                  req_unsigned;
  logic [31:0]           rdata;
  logic                  success;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_we;
  logic [31:0]           mem_rdata;
`ifdef DMC_ALIGN_CHECK_EN
  logic                  misaligned;
`endif
  modport master (
    output req_read, req_write, req_addr, req_wdata, req_byte, req_half, req_unsigned, mem_rdata,
    input  rdata, success, mem_addr, mem_wdata, mem_we
`ifdef DMC_ALIGN_CHECK_EN
    , input misaligned
`endif
  );
  modport slave (
    input  req_read, req_write, req_addr, req_wdata, req_byte, req_half, req_unsigned, mem_rdata,
    output rdata, success, mem_addr, mem_wdata, mem_we
`ifdef DMC_ALIGN_CHECK_EN
    , output misaligned
`endif
  );
endinterface

// File: rtl/data_memory_controller_lane_unit.sv
// dmc_lane_unit: combinational lane extract/extend for loads and lane merge for sub-word stores.
module dmc_lane_unit
  import dmc_pkg::*;
(
  input  size_e       i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_load_word,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_old_word,
  output logic [31:0] o_load_ext,
  output logic [31:0] o_merged
);
  logic [4:0]  w_shift;
  logic [31:0] w_mask;
  logic [31:0] w_lane;
  always_comb begin
    w_shift = i_size == SZ_BYTE ? {i_addr_lo, 3'b000} : i_size == SZ_HALF ? {i_addr_lo[1], 4'b0000} : 5'd0;
    w_mask = i_size == SZ_BYTE ? 32'h0000_00ff : i_size == SZ_HALF ? 32'h0000_ffff : 32'hffff_ffff;
    w_lane = (i_load_word >> w_shift) & w_mask;
    o_load_ext = i_size == SZ_BYTE ? {{(WORD_W-BYTE_W){~i_unsigned & w_lane[BYTE_W-1]}}, w_lane[BYTE_W-1:0]} :
                 i_size == SZ_HALF ? {{(WORD_W-HALF_W){~i_unsigned & w_lane[HALF_W-1]}}, w_lane[HALF_W-1:0]} :
                 w_lane;
    o_merged = (i_old_word & ~(w_mask << w_shift)) | ((i_store_data & w_mask) << w_shift);
  end
endmodule

// File: rtl/data_memory_controller.sv
// data_memory_controller: byte/half/word loads and stores onto a word RAM, sub-word stores via read-modify-write.
// Optional alignment trap enabled by DMC_ALIGN_CHECK_EN.
module data_memory_controller
  import dmc_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input logic                     clk,
  input logic                     rst,
  data_memory_controller_if.slave io_bus
);
  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_rdata;
  logic [31:0] w_load_ext;
  logic [31:0] w_merged;
  size_e       w_size;
  logic        w_wr;
  logic        w_rd;
  logic        w_mis;
  assign w_size = dec_size(io_bus.req_byte, io_bus.req_half);
  assign w_wr   = io_bus.req_write;
  assign w_rd   = io_bus.req_read & ~io_bus.req_write;
`ifdef DMC_ALIGN_CHECK_EN
  assign w_mis = (w_wr | w_rd) & ((w_size == SZ_HALF & io_bus.req_addr[0]) | (w_size == SZ_WORD & |io_bus.req_addr[1:0]));
`else
  assign w_mis = 1'b0;
`endif
  dmc_lane_unit u_lane (
    .i_size       (w_size),
    .i_addr_lo    (io_bus.req_addr[1:0]),
    .i_unsigned   (io_bus.req_unsigned),
    .i_load_word  (io_bus.mem_rdata),
    .i_store_data (io_bus.req_wdata),
    .i_old_word   (io_bus.mem_rdata),
    .o_load_ext   (w_load_ext),
    .o_merged     (w_merged)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_rdata <= io_bus.rdata;
    end
  end
  always_comb begin
    w_next = r_state == IDLE && !w_mis ? (w_wr && w_size != SZ_WORD ? MERGE : w_rd ? LOAD : IDLE) : IDLE;
  end
  // mem_we is gated by rst so a write in flight is killed the instant reset asserts
  always_comb begin
    io_bus.success   = !(r_state == IDLE && !w_mis && ((w_wr && w_size != SZ_WORD) || w_rd));
    io_bus.mem_we    = rst && !w_mis && w_wr && (r_state == IDLE ? w_size == SZ_WORD : r_state == MERGE);
    io_bus.mem_wdata = io_bus.mem_we ? (r_state == MERGE ? w_merged : io_bus.req_wdata) : '0;
    io_bus.rdata     = r_state == LOAD && w_rd ? w_load_ext : (w_mis && w_rd) ? '0 : r_rdata;
    io_bus.mem_addr  = io_bus.req_addr[ADDR_WIDTH+1:2];
`ifdef DMC_ALIGN_CHECK_EN
    io_bus.misaligned = rst && w_mis && r_state == IDLE;
`endif
  end
endmodule

// File: tb/tb_data_memory_controller.sv
// tb_data_memory_controller: random and directed loads/stores checked against a byte-array memory model.
module tb_data_memory_controller;
`ifdef DMC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  data_memory_controller_if #(.ADDR_WIDTH(10)) bus();
  data_memory_controller #(.ADDR_WIDTH(10)) dut (.clk(clk), .rst(rst), .io_bus(bus));
  bit [31:0] ram [1024];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end
  bit [7:0] gb [4096];
  int tests = 0;
  int fails = 0;
  logic t_rd, t_wr, t_b, t_h, t_u, t_mis;
  logic [31:0] t_addr, t_wdata;
  int lat, cyc;
  bit pending = 1'b0;
  bit done;
  bit exp_write, exp_load;
  logic [31:0] exp_rdata, exp_word, got_rdata, got_wdata;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int nbytes(logic b, logic h);
    return b ? 1 : h ? 2 : 4;
  endfunction
  function automatic int first_byte(logic [31:0] a, logic b, logic h);
    return b ? int'(a[11:0]) : h ? int'({a[11:1], 1'b0}) : int'({a[11:2], 2'b00});
  endfunction
  function automatic bit is_mis(logic [31:0] a, logic b, logic h);
    return ALIGN_EN && !b && (h ? a[0] : a[1:0] != 2'b00);
  endfunction
  function automatic logic [31:0] gword(logic [31:0] a);
    int s = first_byte(a, 1'b0, 1'b0);
    return {gb[s+3], gb[s+2], gb[s+1], gb[s]};
  endfunction
  function automatic logic [31:0] load_val(logic [31:0] a, logic b, logic h, logic u);
    int s = first_byte(a, b, h);
    int n = nbytes(b, h);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v |= 32'(gb[s+i]) << (8*i);
    if (!u && n < 4 && v[8*n-1]) v |= 32'hffff_ffff << (8*n);
    return v;
  endfunction
  function automatic logic [31:0] new_word(logic [31:0] a, logic b, logic h, logic [31:0] wd);
    int base = first_byte(a, 1'b0, 1'b0);
    int s = first_byte(a, b, h);
    bit [7:0] wb [4];
    for (int i = 0; i < 4; i++) wb[i] = gb[base+i];
    for (int i = 0; i < nbytes(b, h); i++) wb[s-base+i] = wd[8*i +: 8];
    return {wb[3], wb[2], wb[1], wb[0]};
  endfunction
  always @(negedge clk) begin
    if (pending && rst) begin
      chk("success", 32'(bus.success), 32'(cyc == lat-1));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_write && cyc == lat-1));
      chk("mem_addr", 32'(bus.mem_addr), 32'(t_addr[11:2]));
      if (cyc == lat-1) begin
        if (exp_write) chk("mem_wdata", bus.mem_wdata, exp_word);
        if (exp_load) chk("rdata", bus.rdata, exp_rdata);
`ifdef DMC_ALIGN_CHECK_EN
        chk("misaligned", 32'(bus.misaligned), 32'(t_mis));
`endif
        got_rdata = bus.rdata;
        got_wdata = bus.mem_wdata;
        done = 1'b1;
      end
      cyc++;
    end
  end
  task automatic drive(logic rd, logic wr, logic [31:0] a, logic [31:0] wd, logic b, logic h, logic u);
    bus.req_read = rd; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = wd;
    bus.req_byte = b; bus.req_half = h; bus.req_unsigned = u;
  endtask
  // Called right after a rising edge; returns on the rising edge that completes the access.
  task automatic issue(logic rd, logic wr, logic [31:0] a, logic [31:0] wd, logic b, logic h, logic u);
    #1 drive(rd, wr, a, wd, b, h, u);
    t_rd = rd; t_wr = wr; t_addr = a; t_wdata = wd; t_b = b; t_h = h; t_u = u;
    t_mis = (rd || wr) && is_mis(a, b, h);
    lat = (t_mis || (!rd && !wr) || (wr && nbytes(b, h) == 4)) ? 1 : 2;
    exp_write = wr && !t_mis;
    exp_load = rd && !wr;
    exp_rdata = t_mis ? 32'h0 : load_val(a, b, h, u);
    exp_word = new_word(a, b, h, wd);
    cyc = 0; done = 1'b0; pending = 1'b1;
    for (int k = 0; k < 8 && !done; k++) @(posedge clk);
    if (!done) begin
      tests++; fails++;
      $display("FAIL timeout: no success within 8 cycles for addr %h", a);
    end
    if (exp_write) for (int i = 0; i < nbytes(b, h); i++) gb[first_byte(a, b, h)+i] = wd[8*i +: 8];
    pending = 1'b0;
  endtask
  task automatic abort_mid(logic rd, logic wr, logic [31:0] a);
    #1 drive(rd, wr, a, 32'h0000_00c3, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, a, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("abort_success", 32'(bus.success), 32'd1);
    chk("abort_we", 32'(bus.mem_we), 32'd0);
    @(posedge clk);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 chk("reset_success", 32'(bus.success), 32'd1);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 32'h10, 32'hdeadbeef, 1'b0, 1'b0, 1'b0);
    chk("lit_word_store", got_wdata, 32'hdeadbeef);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_word_load", got_rdata, 32'hdeadbeef);
    issue(1'b0, 1'b1, 32'h10, 32'h11223344, 1'b0, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 32'h11, 32'h0000_00aa, 1'b1, 1'b0, 1'b0);
    chk("lit_byte_merge", got_wdata, 32'h1122aa44);
    issue(1'b1, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("lit_lb_signed", got_rdata, 32'hffffffaa);
    issue(1'b1, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("lit_lb_unsigned", got_rdata, 32'h000000aa);
    issue(1'b1, 1'b0, 32'h12, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_lh_signed", got_rdata, 32'h00001122);
    issue(1'b0, 1'b1, 32'h22, 32'h0000_5555, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 1'b1, 32'h20, 32'h0000_6666, 1'b0, 1'b1, 1'b0);
    chk("lit_half_merge", got_wdata, 32'h55556666);
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_b2b_halves", got_rdata, 32'h55556666);
    issue(1'b1, 1'b1, 32'hffff_f030, 32'hcafef00d, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("lit_wrap_rw", got_rdata, 32'hcafef00d);
    issue(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 1'b1);
`ifdef DMC_ALIGN_CHECK_EN
    issue(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("lit_misaligned_rdata", got_rdata, 32'h0);
    chk("lit_misaligned_lat", 32'(cyc), 32'd1);
`endif
    abort_mid(1'b1, 1'b0, 32'h10);
    abort_mid(1'b0, 1'b1, 32'h10);
    #1 drive(1'b0, 1'b1, 32'h10, 32'h0000_0077, 1'b1, 1'b0, 1'b0);
    @(negedge clk) chk("rmw_read_we", 32'(bus.mem_we), 32'd0);
    @(negedge clk) chk("merge_we", 32'(bus.mem_we), 32'd1);
    #1 rst = 1'b0;
    #1 chk("async_we_kill", 32'(bus.mem_we), 32'd0);
    chk("async_rdata", bus.rdata, 32'h0);
    drive(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("reset_idle_success", 32'(bus.success), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_no_write", ram[4], gword(32'h10));
    @(posedge clk);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 300; n++) begin
      int kind = $urandom_range(0, 9);
      a = $urandom & 32'hffff_f01f;
      issue(kind >= 5 || kind == 0, kind >= 1 && kind <= 4 || kind == 0, a, $urandom,
            $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (kind == 9) issue(1'b0, 1'b0, a, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory_controller.md
Name: data_memory_controller

Overview:
Sits directly downstream of the CPU MEM stage, between the EX/MEM barrier outputs and a single-port, word-wide synchronous RAM without byte enables. Converts byte/half/word loads and stores into RAM cycles. Sub-word stores use read-modify-write. Drives a success flag that the FreezeUnit uses to freeze the pipeline while an access is in flight. Loads are returned little-endian, sign- or zero-extended.

Parameters:
ADDR_WIDTH, 10, word-address bits of the RAM (depth 2^ADDR_WIDTH words)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
req_read  input  1  load request from MEM stage; held stable while success=0
req_write  input  1  store request; held stable while success=0
req_addr  input  32  byte address
req_wdata  input  32  store data (low byte/half used for sub-word)
req_byte  input  1  byte access
req_half  input  1  halfword access (req_byte has priority)
req_unsigned  input  1  zero-extend load
rdata  output  32  extended load result, valid when success=1 and req_read
success  output  1  access complete this cycle; 1 when no request
mem_addr  output  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2]
mem_wdata  output  32  RAM write data
mem_we  output  1  RAM write enable
mem_rdata  input  32  RAM read data, valid 1 cycle after mem_addr

Behaviour:
- FSM states: IDLE, LOAD, MERGE. Reset (rst=0, async): state=IDLE, mem_we=0, mem_wdata=0, rdata=0, success=1 once idle with no request.
- Address wrap: bits above ADDR_WIDTH+1 ignored (modulo RAM size).
- IDLE, no request: success=1, mem_we=0.
- IDLE, word store: mem_we=1, mem_wdata=req_wdata, success=1 same cycle; stay IDLE. Latency 1.
- IDLE, sub-word store: mem_we=0, success=0, go MERGE. In MERGE, mem_rdata holds the old word. Replace lane(s) selected by req_addr[1:0] (byte: lane addr[1:0]; half: lanes addr[1]*2 +0/+1). Drive mem_we=1, success=1, go IDLE. Latency 2.
- IDLE, load: success=0, go LOAD. In LOAD, select byte/half/word of mem_rdata by addr[1:0]; sign-extend unless req_unsigned; drive rdata combinationally, success=1, go IDLE. Latency 2.
- req_read and req_write both 1: write wins, read ignored.
- Request deasserted while in LOAD/MERGE: return IDLE, no write, success=1.
- Back-to-back requests: the IDLE cycle after completion starts the next request, so repeated stores to one address always re-read.
- Reset asserted mid-MERGE: write suppressed immediately (mem_we forced 0 asynchronously), state=IDLE.
- rdata holds its last value when not in LOAD.

Optional Feature:
Macro DMC_ALIGN_CHECK_EN.
- Defined: adds output misaligned (1 bit), asserted when a half access has addr[0]=1 or a word access has addr[1:0]!=0. Such an access completes in 1 cycle (success=1, mem_we=0, rdata=0) and is not performed. misaligned resets to 0.
- Undefined: no port; misaligned low bits are ignored (half uses addr[1], word uses lane 0).

Decomposition:
- Shared package dmc_pkg holds the state enum (IDLE/LOAD/MERGE), the access-size encoding, and lane-width constants.
- One sub-module, dmc_lane_unit, is natural. It is purely combinational: extracts and extends load data, and merges store data by size and addr[1:0]. The FSM stays in the top.

Test Plan:
- Reset: rst=0 mid-MERGE -> mem_we=0 immediately; after release with no request, success=1, rdata=0.
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> store success in 1 cycle; load success in cycle 2 with rdata=0xDEADBEEF.
- Byte store 0xAA @0x11 over 0x11223344 -> one read cycle, then write 0x1122AA44; success low exactly 1 cycle.
- Signed byte load @0x11 of 0x1122AA44 -> 0xFFFFFFAA; with req_unsigned -> 0x000000AA. Signed half load @0x12 -> 0x00001122.
- Back-to-back half stores 0x5555 @0x22 then 0x6666 @0x20 -> final word 0x55556666; no lost update.
- With DMC_ALIGN_CHECK_EN defined, half load @0x13 -> misaligned=1, success=1 in 1 cycle, rdata=0, mem_we=0.
